ace_sysctl: RTL
===============

# ace_sysctl

System sequencing controller for the Jupiter ACE top level, running in the 6.5 MHz video clock domain. It generates the core reset from a power-on counter and the keyboard reset request, with a minimum stretch after release. It owns the scandoubler mode register: keyboard mode requests are latched and applied only at vertical sync, and the video is blanked for a fixed number of frames after each switch.

## Interface
Parameters:
- POR_CYCLES, 16: clk cycles core reset is held after `rst_n` deasserts (≥1)
- RST_STRETCH, 4096: clk cycles core reset is held after `kbd_reset_n` releases (≥1)
- BLANK_FRAMES, 2: vsync starts of blanking after a mode switch (≥1, ≤15)
- MODE_INIT, 2'b11: reset mode, {disable_scaneffect, enable_scandoubling}

Ports:
- clk  in  1  6.5 MHz video clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- kbd_reset_n  in  1  keyboard reset request, active-low, asynchronous to clk
- change_video_output  in  1  keyboard mode-cycle request, level, asynchronous
- vsync_n  in  1  PAL vsync from core, active-low
- core_reset_n  out  1  reset to the core, active-low, registered
- mode  out  2  current scandoubler mode, registered
- enable_scandoubling  out  1  equals mode[0]
- disable_scaneffect  out  1  equals mode[1]
- video_blank  out  1  high means force video black, registered

## Operation
- Inputs: `kbd_reset_n`, `change_video_output` and `vsync_n` each pass through a 2-flop synchronizer.
  - `change_video_output` gets rising-edge detection after the synchronizer.
  - `vsync_n` gets falling-edge detection (vsync start, `vs_start`) after the synchronizer.
- Reset FSM states: POR, RUN, KHOLD, KSTRETCH.
  - POR: counter runs. Go to RUN when the count reaches POR_CYCLES.
  - RUN: go to KHOLD when synchronized `kbd_reset_n` = 0.
  - KHOLD: stay while `kbd_reset_n` = 0. On release, load the stretch counter and go to KSTRETCH.
  - KSTRETCH: count RST_STRETCH cycles, then go to RUN. If `kbd_reset_n` reasserts here, return to KHOLD and restart the stretch on the next release.
  - `core_reset_n` = 1 only in RUN.
- Mode sequence: `next(11)=01`, `next(01)=00`, `next(00)=11`, `next(10)=11` (10 is illegal and self-heals).
- Mode request: a rising edge sets `pending` and sets `target = next(pending ? target : mode)`. Repeated presses before apply keep advancing `target`.
- Apply: on `vs_start` with `pending` set:
  - `mode <= target` and `pending <= 0`.
  - Load the blank counter with BLANK_FRAMES.
- Simultaneous press edge and `vs_start`: the apply uses the target already advanced by that press. `pending` ends at 0.
- Blank counter: decrements on each `vs_start` after the apply cycle while non-zero. Saturates at 0.
- `video_blank` = 1 when `core_reset_n` = 0 or the blank counter ≠ 0.
- Mode requests are accepted in every reset FSM state. Mode is not reset by a keyboard reset.
- Reset values while `rst_n` = 0:
  - state POR, counters 0, `pending` = 0, `target` = MODE_INIT
  - `mode` = MODE_INIT, `core_reset_n` = 0, `video_blank` = 1
  - synchronizer flops: ones for `kbd_reset_n` and `vsync_n`, zero for `change_video_output`
- `rst_n` asserted mid-operation aborts everything immediately and asynchronously. Pending requests are lost.

## Timing
- `core_reset_n` rises on the POR_CYCLES-th rising clk edge after `rst_n` deasserts.
- `core_reset_n` falls on the 3rd clk edge after `kbd_reset_n` falls (2 sync edges plus 1 FSM edge).
- `core_reset_n` rises RST_STRETCH+3 edges after `kbd_reset_n` rises.
- `pending` sets on the 3rd edge after `change_video_output` rises.
- `mode` and the derived outputs update on the 3rd edge after `vsync_n` falls. `video_blank` rises on the same edge.
- `video_blank` falls on the 3rd edge after the BLANK_FRAMES-th subsequent `vsync_n` fall (provided `core_reset_n` = 1).
- Counter widths: `$clog2(param+1)`.

## Configuration
- `ACE_SYSCTL_VSYNC_ALIGN_EN`
  - Defined: mode apply waits for `vs_start`, as described above.
  - Undefined: apply occurs on the clock edge after `pending` sets, with no vsync wait. Blanking still counts `vs_start` events.

## Test plan
Bench parameters for all scenarios: POR_CYCLES=16, RST_STRETCH=8, BLANK_FRAMES=2, MODE_INIT=11, macro defined.
- Power-on: release `rst_n` → `core_reset_n` = 0 for 15 edges, 1 at edge 16. `mode` = 11 and `video_blank` = 1 throughout POR.
- Keyboard reset: pulse `kbd_reset_n` low 20 cycles → `core_reset_n` low from edge 3 after the fall until 11 edges after the rise. A re-pulse during stretch restarts the 8-cycle stretch.
- Mode cycle: one press, then a vsync fall → `mode` goes 11→01 exactly 3 edges after the fall. `video_blank` = 1 until the 2nd later vsync fall + 3 edges.
- Multiple presses: three presses before vsync → a single apply to `mode` = 11 (11→01→00→11). `pending` = 0 afterwards.
- Collision and illegal mode: press edge coinciding with `vs_start` from `mode` = 01 → `mode` = 00. Forced `mode` = 10 plus a press → 11.
- Mid-operation reset: assert `rst_n` with `pending` = 1 and blank count = 1 → all outputs at reset values immediately. No apply on the next vsync.

Source files
------------

// File: rtl/ace_sysctl.sv
// ace_sysctl - system sequencing controller for the Jupiter ACE top level.
//
// Produces the core reset from a power-on counter and the keyboard reset
// request (with a post-release stretch), and owns the scandoubler mode
// register. Mode-cycle requests from the keyboard are collected into a
// pending target and applied at vertical sync start; video is then forced
// black for BLANK_FRAMES vsync starts.
//
// Build option:
//   ACE_SYSCTL_VSYNC_ALIGN_EN  defined   -> mode change waits for vsync start
//                              undefined -> mode change on the edge after the
//                                           request is registered
//
// Ports:
//   clk                  in   6.5 MHz video clock (only clock)
//   rst_n                in   asynchronous active-low reset
//   kbd_reset_n          in   keyboard reset request, active-low, async
//   change_video_output  in   keyboard mode-cycle request, level, async
//   vsync_n              in   PAL vsync from core, active-low
//   core_reset_n         out  active-low core reset, registered
//   mode[1:0]            out  {disable_scaneffect, enable_scandoubling}
//   enable_scandoubling  out  mode[0]
//   disable_scaneffect   out  mode[1]
//   video_blank          out  force video black, registered

module ace_sysctl #(
    parameter int unsigned POR_CYCLES   = 16,
    parameter int unsigned RST_STRETCH  = 4096,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter logic [1:0]  MODE_INIT    = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_reset_n,
    input  logic       change_video_output,
    input  logic       vsync_n,
    output logic       core_reset_n,
    output logic [1:0] mode,
    output logic       enable_scandoubling,
    output logic       disable_scaneffect,
    output logic       video_blank
);

    localparam int POR_W = $clog2(POR_CYCLES + 1);
    localparam int STR_W = $clog2(RST_STRETCH + 1);
    localparam int BLK_W = $clog2(BLANK_FRAMES + 1);

    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RST_STRETCH);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_FRAMES);

    // Synchronizer bit order: {vsync_n, change_video_output, kbd_reset_n}.
    // Idle levels are used as reset values so no spurious edge is seen.
    localparam logic [2:0] SYNC_INIT = 3'b101;

    typedef enum logic [1:0] {S_POR, S_RUN, S_KHOLD, S_KSTRETCH} state_t;

    logic [2:0]       meta_reg;
    logic [2:0]       sync_reg;
    logic [1:0]       prev_reg;       // {vsync, change_video_output} delayed
    logic             press;
    logic             vs_start;
    logic             kbd_sync;
    logic             apply;

    state_t           state_reg;
    logic [POR_W-1:0] por_cnt_reg;
    logic [STR_W-1:0] stretch_cnt_reg;
    logic             core_reset_n_reg;
    logic             video_blank_reg;

    logic             pending_reg, pending_next;
    logic [1:0]       target_reg, target_next;
    logic [1:0]       mode_reg, mode_next;
    logic [BLK_W-1:0] blank_reg, blank_next;

    function automatic logic [1:0] mode_step(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'b11:   r = 2'b01;
            2'b01:   r = 2'b00;
            2'b00:   r = 2'b11;
            default: r = 2'b11;   // 10 is not a legal mode; recover to 11
        endcase
        return r;
    endfunction

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= SYNC_INIT;
            sync_reg <= SYNC_INIT;
            prev_reg <= SYNC_INIT[2:1];
        end else begin
            meta_reg <= {vsync_n, change_video_output, kbd_reset_n};
            sync_reg <= meta_reg;
            prev_reg <= sync_reg[2:1];
        end
    end

    assign kbd_sync = sync_reg[0];
    assign press    = sync_reg[1] & ~prev_reg[0];
    assign vs_start = ~sync_reg[2] & prev_reg[1];

`ifdef ACE_SYSCTL_VSYNC_ALIGN_EN
    // A press landing on the same edge as vsync start is folded into the apply.
    assign apply = vs_start & (pending_reg | press);
`else
    assign apply = pending_reg;
`endif

    always_comb begin
        pending_next = pending_reg;
        target_next  = target_reg;
        mode_next    = mode_reg;
        blank_next   = blank_reg;
        if (press) begin
            pending_next = 1'b1;
            target_next  = mode_step(pending_reg ? target_reg : mode_reg);
        end
        if (apply) begin
            mode_next    = target_next;
            pending_next = 1'b0;
            blank_next   = BLK_LOAD;
        end else if (vs_start && blank_reg != '0) begin
            blank_next = blank_reg - BLK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            target_reg  <= MODE_INIT;
            mode_reg    <= MODE_INIT;
            blank_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            target_reg  <= target_next;
            mode_reg    <= mode_next;
            blank_reg   <= blank_next;
        end
    end

    // Reset sequencer. Outputs are registered from the next state so that
    // core_reset_n and video_blank change on the same edge as the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_POR;
            por_cnt_reg      <= '0;
            stretch_cnt_reg  <= '0;
            core_reset_n_reg <= 1'b0;
            video_blank_reg  <= 1'b1;
        end else begin
            core_reset_n_reg <= 1'b0;
            video_blank_reg  <= 1'b1;
            case (state_reg)
                S_POR: begin
                    if (por_cnt_reg == POR_LAST) begin
                        state_reg        <= S_RUN;
                        core_reset_n_reg <= 1'b1;
                        video_blank_reg  <= (blank_next != '0);
                    end else begin
                        por_cnt_reg <= por_cnt_reg + POR_W'(1);
                    end
                end
                S_RUN: begin
                    if (!kbd_sync) begin
                        state_reg <= S_KHOLD;
                    end else begin
                        core_reset_n_reg <= 1'b1;
                        video_blank_reg  <= (blank_next != '0);
                    end
                end
                S_KHOLD: begin
                    if (kbd_sync) begin
                        stretch_cnt_reg <= STR_LOAD;
                        state_reg       <= S_KSTRETCH;
                    end
                end
                S_KSTRETCH: begin
                    if (!kbd_sync) begin
                        state_reg <= S_KHOLD;   // stretch restarts on next release
                    end else if (stretch_cnt_reg == STR_W'(1)) begin
                        state_reg        <= S_RUN;
                        core_reset_n_reg <= 1'b1;
                        video_blank_reg  <= (blank_next != '0);
                    end else begin
                        stretch_cnt_reg <= stretch_cnt_reg - STR_W'(1);
                    end
                end
                default: state_reg <= S_POR;
            endcase
        end
    end

    assign core_reset_n        = core_reset_n_reg;
    assign mode                = mode_reg;
    assign enable_scandoubling = mode_reg[0];
    assign disable_scaneffect  = mode_reg[1];
    assign video_blank         = video_blank_reg;

endmodule
